// File: rtl/action_pkg.sv
// rtl/action_pkg.sv - shared types and defaults for the action event queue
package action_pkg;

    typedef enum logic {
        IDLE    = 1'b0,
        HOLDOFF = 1'b1
    } state_t;

    localparam int DEF_SYNC_STAGES    = 2;
    localparam int DEF_HOLDOFF_CYCLES = 16;
    localparam int DEF_DEPTH          = 4;
    localparam int SEQ_W              = 4;
    localparam int CNT_W              = 3;

endpackage

// File: rtl/action_sync.sv
// rtl/action_sync.sv - action level synchronizer with rising-edge detect
module action_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset_n,
    input  logic action_i,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], action_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // prev resets low, so a level already high at reset release counts as a rise
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/action_event_queue.sv
// rtl/action_event_queue.sv - debounced action event counter with holdoff and overflow flag
module action_event_queue
    import action_pkg::*;
#(
    parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
    parameter int HOLDOFF_CYCLES = DEF_HOLDOFF_CYCLES,
    parameter int DEPTH          = DEF_DEPTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             action_in,
    input  logic             evt_ready,
    input  logic             ovf_clr,
    output logic             evt_valid,
    output logic [SEQ_W-1:0] evt_seq,
    output logic [CNT_W-1:0] pending_cnt,
    output logic             overflow,
    output logic             holdoff
);

    localparam int               HW        = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
    localparam logic [HW-1:0]    HOLD_LOAD = HW'(HOLDOFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(DEPTH);

    state_t           state_q;
    logic [HW-1:0]    hold_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SEQ_W-1:0] seq_q, seq_d;
    logic             ovf_q, ovf_d;
    logic             rise;
    logic             accept;
    logic             pop;
    logic             full;

    action_sync #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .action_i(action_in),
        .rise_o  (rise)
    );

    always_comb begin
        accept = (state_q == IDLE) && rise;
        pop    = (cnt_q != '0) && evt_ready;
        full   = (cnt_q == DEPTH_C);
        cnt_d  = cnt_q;
        if (accept && !pop && !full) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !accept) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        seq_d = pop ? (seq_q + SEQ_W'(1)) : seq_q;
        // a fresh overflow wins over a same-cycle clear
        ovf_d = (ovf_q & ~ovf_clr) | (accept & full & ~pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            hold_q  <= '0;
            cnt_q   <= '0;
            seq_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            seq_q <= seq_d;
            ovf_q <= ovf_d;
            case (state_q)
                IDLE: begin
                    if (rise) begin
                        hold_q  <= HOLD_LOAD;
                        state_q <= HOLDOFF;
                    end
                end
                HOLDOFF: begin
                    if (hold_q == '0) begin
                        state_q <= IDLE;
                    end else begin
                        hold_q <= hold_q - HW'(1);
                    end
                end
            endcase
        end
    end

    assign evt_valid   = (cnt_q != '0);
    assign evt_seq     = seq_q;
    assign pending_cnt = cnt_q;
    assign overflow    = ovf_q;
    assign holdoff     = (state_q == HOLDOFF);

endmodule

// File: tb/tb_action_event_queue.sv
// tb/tb_action_event_queue.sv - self-checking bench for action_event_queue
module tb_action_event_queue;

    localparam int DEPTH = 4;

    logic       clk;
    logic       reset_n;
    logic       action_in;
    logic       evt_ready;
    logic       ovf_clr;
    logic       evt_valid;
    logic [3:0] evt_seq;
    logic [2:0] pending_cnt;
    logic       overflow;
    logic       holdoff;

    int checks   = 0;
    int failures = 0;
    int sb[$];
    int model_head;
    bit exp_ovf;

    action_event_queue dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .action_in  (action_in),
        .evt_ready  (evt_ready),
        .ovf_clr    (ovf_clr),
        .evt_valid  (evt_valid),
        .evt_seq    (evt_seq),
        .pending_cnt(pending_cnt),
        .overflow   (overflow),
        .holdoff    (holdoff)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cyc(2);
        reset_n = 1'b1;
        sb.delete();
        model_head = 0;
        exp_ovf    = 1'b0;
    endtask

    // Raise action after a low gap; optionally pop or clear on the accept edge.
    task automatic pulse(input bit pop_at_accept, input bit clr_at_accept);
        action_in = 1'b0;
        cyc(2);
        action_in = 1'b1;
        cyc(2);
        evt_ready = pop_at_accept;
        ovf_clr   = clr_at_accept;
        if (pop_at_accept && sb.size() > 0) begin
            void'(sb.pop_front());
            model_head = (model_head + 1) % 16;
        end
        if (clr_at_accept) exp_ovf = 1'b0;
        if (sb.size() < DEPTH) sb.push_back((model_head + sb.size()) % 16);
        else exp_ovf = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        ovf_clr   = 1'b0;
        cyc(20);
    endtask

    task automatic test_reset();
        action_in = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
        do_reset();
        cyc(2);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL rst_valid got=%0d exp=0", evt_valid); end
        checks++; if (evt_seq !== 4'd0) begin failures++; $display("FAIL rst_seq got=%0d exp=0", evt_seq); end
        checks++; if (pending_cnt !== 3'd0) begin failures++; $display("FAIL rst_cnt got=%0d exp=0", pending_cnt); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL rst_ovf got=%0d exp=0", overflow); end
        checks++; if (holdoff !== 1'b0) begin failures++; $display("FAIL rst_holdoff got=%0d exp=0", holdoff); end
    endtask

    task automatic test_ready_idle();
        evt_ready = 1'b1;
        cyc(3);
        evt_ready = 1'b0;
        checks++; if (evt_seq !== 4'd0) begin failures++; $display("FAIL idle_ready_seq got=%0d exp=0", evt_seq); end
        checks++; if (pending_cnt !== 3'd0) begin failures++; $display("FAIL idle_ready_cnt got=%0d exp=0", pending_cnt); end
    endtask

    task automatic test_single_event();
        int n;
        action_in = 1'b0;
        do_reset();
        cyc(2);
        action_in = 1'b1;
        cyc(2);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%0d exp=0", evt_valid); end
        cyc(1);
        checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL single_valid_edge3 got=%0d exp=1", evt_valid); end
        checks++; if (evt_seq !== 4'd0) begin failures++; $display("FAIL single_seq got=%0d exp=0", evt_seq); end
        checks++; if (pending_cnt !== 3'd1) begin failures++; $display("FAIL single_cnt got=%0d exp=1", pending_cnt); end
        n = (holdoff === 1'b1) ? 1 : 0;
        for (int i = 0; i < 40; i++) begin
            cyc(1);
            if (holdoff === 1'b1) n++;
        end
        checks++; if (n != 16) begin failures++; $display("FAIL single_holdoff_len got=%0d exp=16", n); end
        checks++; if (pending_cnt !== 3'd1) begin failures++; $display("FAIL single_no_second got=%0d exp=1", pending_cnt); end
        action_in = 1'b0;
    endtask

    task automatic test_overflow();
        action_in = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b0);
        checks++; if (pending_cnt !== 3'(sb.size())) begin failures++; $display("FAIL ovf_fill_cnt got=%0d exp=%0d", pending_cnt, sb.size()); end
        checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL ovf_fill_flag got=%0d exp=%0d", overflow, exp_ovf); end
        pulse(1'b0, 1'b0);
        checks++; if (pending_cnt !== 3'd4) begin failures++; $display("FAIL ovf_full_cnt got=%0d exp=4", pending_cnt); end
        checks++; if (overflow !== exp_ovf || exp_ovf !== 1'b1) begin failures++; $display("FAIL ovf_set got=%0d exp=1", overflow); end
        ovf_clr = 1'b1;
        cyc(1);
        ovf_clr = 1'b0;
        exp_ovf = 1'b0;
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL ovf_clear got=%0d exp=0", overflow); end
        pulse(1'b0, 1'b1);
        checks++; if (overflow !== exp_ovf) begin failures++; $display("FAIL ovf_clr_collide got=%0d exp=%0d", overflow, exp_ovf); end
        for (int i = 0; i < 8 && evt_valid === 1'b1; i++) begin
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL ovf_drain_extra got=%0d exp=none", evt_seq); end
            else if (evt_seq !== 4'(sb[0])) begin failures++; $display("FAIL ovf_drain_seq got=%0d exp=%0d", evt_seq, sb[0]); end
            evt_ready = 1'b1;
            cyc(1);
            evt_ready = 1'b0;
            if (sb.size() > 0) void'(sb.pop_front());
        end
        checks++; if (pending_cnt !== 3'(sb.size())) begin failures++; $display("FAIL ovf_drain_cnt got=%0d exp=%0d", pending_cnt, sb.size()); end
        action_in = 1'b0;
    endtask

    task automatic test_holdoff_discard();
        action_in = 1'b0;
        do_reset();
        cyc(2);
        action_in = 1'b1;
        cyc(2);
        action_in = 1'b0;
        cyc(2);
        action_in = 1'b1;
        cyc(40);
        checks++; if (pending_cnt !== 3'd1) begin failures++; $display("FAIL discard_cnt got=%0d exp=1", pending_cnt); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL discard_ovf got=%0d exp=0", overflow); end
        action_in = 1'b0;
    endtask

    task automatic test_full_pop_accept();
        action_in = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) pulse(1'b0, 1'b0);
        pulse(1'b1, 1'b0);
        checks++; if (pending_cnt !== 3'd4) begin failures++; $display("FAIL fullpop_cnt got=%0d exp=4", pending_cnt); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL fullpop_ovf got=%0d exp=0", overflow); end
        checks++; if (evt_seq !== 4'(model_head)) begin failures++; $display("FAIL fullpop_seq got=%0d exp=%0d", evt_seq, model_head); end
        for (int i = 0; i < 8 && evt_valid === 1'b1; i++) begin
            checks++;
            if (sb.size() == 0) begin failures++; $display("FAIL fullpop_drain_extra got=%0d exp=none", evt_seq); end
            else if (evt_seq !== 4'(sb[0])) begin failures++; $display("FAIL fullpop_drain_seq got=%0d exp=%0d", evt_seq, sb[0]); end
            evt_ready = 1'b1;
            cyc(1);
            evt_ready = 1'b0;
            if (sb.size() > 0) void'(sb.pop_front());
        end
        checks++; if (pending_cnt !== 3'(sb.size())) begin failures++; $display("FAIL fullpop_drain_cnt got=%0d exp=%0d", pending_cnt, sb.size()); end
        action_in = 1'b0;
    endtask

    task automatic test_seq_wrap();
        int exp;
        action_in = 1'b0;
        do_reset();
        for (int i = 0; i < 17; i++) begin
            pulse(1'b0, 1'b0);
            exp = (sb.size() > 0) ? sb.pop_front() : -1;
            checks++;
            if (evt_valid !== 1'b1 || evt_seq !== 4'(exp)) begin
                failures++;
                $display("FAIL wrap_seq idx=%0d got=%0d valid=%0d exp=%0d", i, evt_seq, evt_valid, exp);
            end
            evt_ready = 1'b1;
            cyc(1);
            evt_ready = 1'b0;
            model_head = (model_head + 1) % 16;
        end
        checks++; if (evt_seq !== 4'(model_head)) begin failures++; $display("FAIL wrap_final_seq got=%0d exp=%0d", evt_seq, model_head); end
        action_in = 1'b0;
    endtask

    task automatic test_async_reset();
        action_in = 1'b0;
        do_reset();
        pulse(1'b0, 1'b0);
        evt_ready = 1'b1;
        cyc(1);
        evt_ready = 1'b0;
        pulse(1'b0, 1'b0);
        action_in = 1'b0;
        cyc(2);
        action_in = 1'b1;
        cyc(5);
        checks++; if (holdoff !== 1'b1 || pending_cnt !== 3'd2 || evt_seq !== 4'd1) begin
            failures++; $display("FAIL areset_setup got=h%0d c%0d s%0d exp=h1 c2 s1", holdoff, pending_cnt, evt_seq);
        end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({evt_valid, evt_seq, pending_cnt, overflow, holdoff} !== 10'd0) begin
            failures++; $display("FAIL areset_outputs got=v%0d s%0d c%0d o%0d h%0d exp=all0", evt_valid, evt_seq, pending_cnt, overflow, holdoff);
        end
        @(negedge clk);
        reset_n = 1'b1;
        cyc(2);
        checks++; if (evt_valid !== 1'b0) begin failures++; $display("FAIL release_high_early got=%0d exp=0", evt_valid); end
        cyc(1);
        checks++; if (evt_valid !== 1'b1) begin failures++; $display("FAIL release_high_valid got=%0d exp=1", evt_valid); end
        cyc(30);
        checks++; if (pending_cnt !== 3'd1 || evt_seq !== 4'd0) begin
            failures++; $display("FAIL release_high_once got=c%0d s%0d exp=c1 s0", pending_cnt, evt_seq);
        end
        action_in = 1'b0;
    endtask

    initial begin
        reset_n = 1'b0; action_in = 1'b0; evt_ready = 1'b0; ovf_clr = 1'b0;
        test_reset();
        test_ready_idle();
        test_single_event();
        test_overflow();
        test_holdoff_discard();
        test_full_pop_accept();
        test_seq_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/action_event_queue.md
ACTION_EVENT_QUEUE -- requirements
Module: action_event_queue

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on action_in (min 2).
REQ-002 SHALL have parameter HOLDOFF_CYCLES, default 16, re-trigger lockout length in clk cycles (min 1).
REQ-003 SHALL have parameter DEPTH, default 4, maximum pending events (1..7).
REQ-004 SHALL have port clk, input, 1, system clock, rising-edge active.
REQ-005 SHALL have port reset_n, input, 1, reset, asynchronous, active-low.
REQ-006 SHALL have port action_in, input, 1, level from the software-written action PIO output.
REQ-007 SHALL have port evt_ready, input, 1, game engine ready to consume one event.
REQ-008 SHALL have port ovf_clr, input, 1, synchronous clear of the overflow flag.
REQ-009 SHALL have port evt_valid, output, 1, at least one event pending.
REQ-010 SHALL have port evt_seq, output, 4, sequence number of the event at the head.
REQ-011 SHALL have port pending_cnt, output, 3, number of events pending.
REQ-012 SHALL have port overflow, output, 1, sticky flag: an accepted edge was lost because the queue was full.
REQ-013 SHALL have port holdoff, output, 1, high while the FSM is in HOLDOFF.

Function
REQ-014 SHALL pass action_in through SYNC_STAGES flops, then register the result into a prev flop; rise = sync_out & ~prev.
REQ-015 SHALL use a 2-state FSM: IDLE and HOLDOFF.
REQ-016 In IDLE, on rise, SHALL accept the event: if not full, pending_cnt += 1; load the holdoff counter with HOLDOFF_CYCLES-1; go to HOLDOFF.
REQ-017 In HOLDOFF, SHALL decrement the counter each cycle, ignore rise, and return to IDLE on the cycle the counter equals 0, so HOLDOFF lasts exactly HOLDOFF_CYCLES cycles.
REQ-018 A rise that occurs during HOLDOFF SHALL be discarded; it SHALL NOT be deferred or set overflow.
REQ-019 With defaults, an IDLE/empty block SHALL raise evt_valid on the 3rd rising clk edge after the first edge that samples action_in high.
REQ-020 evt_valid SHALL equal (pending_cnt != 0), registered-derived, with no combinational path from action_in or evt_ready.
REQ-021 A pop SHALL occur when evt_valid && evt_ready at a clock edge: pending_cnt -= 1 and evt_seq += 1, wrapping 15 -> 0.
REQ-022 When an accept and a pop occur in the same cycle, pending_cnt SHALL be unchanged and evt_seq SHALL still increment.
REQ-023 When pending_cnt == DEPTH, an accept with no simultaneous pop SHALL leave pending_cnt at DEPTH and set overflow; the FSM still enters HOLDOFF.
REQ-024 When pending_cnt == DEPTH, an accept with a simultaneous pop SHALL NOT set overflow.
REQ-025 overflow SHALL stay set until ovf_clr; if ovf_clr and a new overflow occur in the same cycle, overflow SHALL remain 1.
REQ-026 evt_ready while evt_valid == 0 SHALL have no effect.
REQ-027 A level held high SHALL generate exactly one event; a new event requires a low sample followed by a high sample after HOLDOFF ends.

Reset
REQ-028 Asserting reset_n low SHALL asynchronously clear all sync flops, prev, the holdoff counter, pending_cnt, evt_seq and overflow, and force state IDLE.
REQ-029 After reset: evt_valid=0, evt_seq=0, pending_cnt=0, overflow=0, holdoff=0.
REQ-030 Reset mid-HOLDOFF or with events pending SHALL discard all state; no event SHALL survive reset.
REQ-031 If action_in is high at reset release, it SHALL produce one event, because prev resets to 0.

Structure
REQ-032 Package action_pkg SHALL hold the FSM state enum (IDLE, HOLDOFF), the default parameter values and the evt_seq width constant (4).
REQ-033 Sub-module action_sync SHALL contain the SYNC_STAGES synchronizer, the prev flop and the rise output; all other logic SHALL reside in action_event_queue.

Verification
REQ-034 Directed test: reset, then action_in 0->1 held -> evt_valid=1 on edge 3, evt_seq=0, pending_cnt=1, holdoff=1 for 16 cycles; no second event.
REQ-035 Directed test: evt_ready=0, five separated pulses (low 2 cycles, then high, each >20 cycles apart) -> pending_cnt=4, overflow=1; ovf_clr pulse -> overflow=0.
REQ-036 Directed test: pulse, then a second rise 5 cycles later inside HOLDOFF -> only one event, overflow=0.
REQ-037 Directed test: pending_cnt=4, evt_ready=1 aligned with an accept -> pending_cnt stays 4, overflow=0, evt_seq increments.
REQ-038 Directed test: 17 accepted-and-popped events -> evt_seq sequence 0..15, 0.
REQ-039 Directed test: reset_n low mid-HOLDOFF with pending_cnt=2 -> all outputs 0 immediately, without waiting for a clk edge.
